muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M-style multiply/divide unit: one radix-2 step per cycle,
// magnitudes in the datapath, sign correction in a separate FIX cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       OP,
  input  logic [XLEN-1:0]  DATA1,
  input  logic [XLEN-1:0]  DATA2,
  input  logic [TAG_W-1:0] TAG_IN,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  RESULT,
  output logic [TAG_W-1:0] TAG_OUT,
  output logic             DIV_ZERO,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a request transfers on a rising edge where IN_VALID && IN_READY
  // && !FLUSH; a result transfers on a rising edge where OUT_VALID && OUT_READY.
  // Neither valid depends combinationally on the matching ready.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              res_neg_q, res_neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              dz_q, dz_d;

  logic              sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_by_zero, div_overflow;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fix_value;

  // Operand decode: only MULHU/DIVU/REMU treat DATA1 as unsigned; MULHSU also
  // treats DATA2 as unsigned.
  always_comb begin
    sgn_a        = OP[2] ? !OP[0] : (OP != OP_MULHU);
    sgn_b        = sgn_a && (OP != OP_MULHSU);
    neg_a        = sgn_a && DATA1[XLEN-1];
    neg_b        = sgn_b && DATA2[XLEN-1];
    mag_a        = neg_a ? -DATA1 : DATA1;
    mag_b        = neg_b ? -DATA2 : DATA2;
    div_by_zero  = OP[2] && (DATA2 == '0);
    div_overflow = OP[2] && !OP[0] && (DATA1 == MOST_NEG) && (DATA2 == '1);
  end

  // Shift-add multiply: low half holds the remaining multiplier bits.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
             + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
  end

  // Restoring divide: {remainder, quotient} shifted left, trial subtract on top.
  always_comb begin
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    if (!div_diff[XLEN]) begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {acc_q[2*XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fixed = res_neg_q ? -acc_q : acc_q;
    quo        = acc_q[XLEN-1:0];
    rem        = acc_q[2*XLEN-1:XLEN];
    fix_value  = '0;
    if (!op_q[2]) begin
      fix_value = (op_q == OP_MUL) ? prod_fixed[XLEN-1:0] : prod_fixed[2*XLEN-1:XLEN];
    end else if (!op_q[1]) begin
      fix_value = res_neg_q ? -quo : quo;
    end else begin
      fix_value = res_neg_q ? -rem : rem;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    res_neg_d = res_neg_q;
    result_d  = result_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          op_d  = OP;
          tag_d = TAG_IN;
          dz_d  = 1'b0;
          if (div_by_zero) begin
            result_d = OP[1] ? DATA1 : '1;
            dz_d     = 1'b1;
            state_d  = S_DONE;
          end else if (div_overflow) begin
            result_d = OP[1] ? '0 : DATA1;
            state_d  = S_DONE;
          end else begin
            acc_d     = {{XLEN{1'b0}}, mag_a};
            opb_d     = mag_b;
            res_neg_d = (OP[2] && OP[1]) ? neg_a : (neg_a ^ neg_b);
            cnt_d     = CNT_W'(XLEN);
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_value;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (OUT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, including a same-cycle acceptance.
    if (FLUSH) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      res_neg_q <= 1'b0;
      result_q  <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      res_neg_q <= res_neg_d;
      result_q  <= result_d;
      dz_q      <= dz_d;
    end
  end

  assign IN_READY    = (state_q == S_IDLE);
  assign OUT_VALID   = (state_q == S_DONE);
  assign RESULT      = OUT_VALID ? result_q : '0;
  assign DIV_ZERO    = OUT_VALID && dz_q;
  assign TAG_OUT     = tag_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32): scoreboard of expected results/tags/latency
// against a behavioural model, plus hold, flush and reset scenarios.
module tb_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b1;
  logic             IN_VALID = 1'b0;
  logic             IN_READY;
  logic [2:0]       OP = '0;
  logic [XLEN-1:0]  DATA1 = '0;
  logic [XLEN-1:0]  DATA2 = '0;
  logic [TAG_W-1:0] TAG_IN = '0;
  logic             FLUSH = 1'b0;
  logic             OUT_VALID;
  logic             OUT_READY = 1'b1;
  logic [XLEN-1:0]  RESULT;
  logic [TAG_W-1:0] TAG_OUT;
  logic             DIV_ZERO;
  logic [1:0]       dbg_state;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP(OP), .DATA1(DATA1), .DATA2(DATA2), .TAG_IN(TAG_IN), .FLUSH(FLUSH),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT),
    .TAG_OUT(TAG_OUT), .DIV_ZERO(DIV_ZERO), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  rand_ready = 1'b0;
  bit  prev_valid = 1'b0;
  int  valid_seen = 0;

  logic [XLEN-1:0]  exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  logic             exp_dz_q[$];
  int               exp_acc_q[$];
  int               exp_lat_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model; lat counts rising edges with the acceptance edge as edge 1.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic dz, output int lat);
    logic [63:0] p;
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dz  = 1'b0;
    lat = 34;
    r   = '0;
    case (op)
      3'd0: r = a * b;
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) begin r = '1; dz = 1'b1; lat = 1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; lat = 1; end
        else r = $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) begin r = '1; dz = 1'b1; lat = 1; end
        else r = a / b;
      end
      3'd6: begin
        if (b == 0) begin r = a; dz = 1'b1; lat = 1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = '0; lat = 1; end
        else r = $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) begin r = a; dz = 1'b1; lat = 1; end
        else r = a % b;
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input bit expect_out);
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) check("in_ready_timeout", 0, 1);
    IN_VALID = 1'b1;
    OP       = op;
    DATA1    = a;
    DATA2    = b;
    TAG_IN   = tag;
    if (expect_out) begin
      model(op, a, b, r, dz, lat);
      exp_q.push_back(r);
      exp_tag_q.push_back(tag);
      exp_dz_q.push_back(dz);
      exp_acc_q.push_back(cyc + 1);
      exp_lat_q.push_back(lat);
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !IN_READY) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0 || !IN_READY) begin
      check("drain_timeout", 1, 0);
      exp_q.delete(); exp_tag_q.delete(); exp_dz_q.delete();
      exp_acc_q.delete(); exp_lat_q.delete();
    end
  endtask

  always @(posedge CLK) begin
    #2;
    if (rand_ready) OUT_READY = ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (OUT_VALID) begin
        valid_seen++;
        if (!prev_valid) begin
          if (exp_acc_q.size() == 0) check("unexpected_valid", 1, 0);
          else check("latency", 64'(cyc - exp_acc_q[0] + 1), 64'(exp_lat_q[0]));
        end
        if (OUT_READY && exp_q.size() != 0) begin
          check("result", RESULT, exp_q.pop_front());
          check("tag_out", TAG_OUT, exp_tag_q.pop_front());
          check("div_zero", DIV_ZERO, exp_dz_q.pop_front());
          void'(exp_acc_q.pop_front());
          void'(exp_lat_q.pop_front());
        end
      end else begin
        check("idle_result", RESULT, 0);
        check("idle_div_zero", DIV_ZERO, 0);
      end
      prev_valid = OUT_VALID;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] hr;
    logic        hdz;
    int          hlat;
    int          n;

    #3 RESET_N = 1'b0;
    #1;
    check("rst_in_ready", IN_READY, 1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_result", RESULT, 0);
    check("rst_tag_out", TAG_OUT, 0);
    check("rst_div_zero", DIV_ZERO, 0);
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #3 RESET_N = 1'b1;

    // Directed vectors
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1);        drain();
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1); drain();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1); drain();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1); drain();
    issue(3'd4, -32'sd7, 32'd2, 5'd5, 1'b1);               drain();
    issue(3'd6, -32'sd7, 32'd2, 5'd6, 1'b1);               drain();
    issue(3'd5, 32'd100, 32'd7, 5'd7, 1'b1);               drain();
    issue(3'd7, 32'd100, 32'd7, 5'd8, 1'b1);               drain();
    issue(3'd5, 32'd5, 32'd0, 5'd10, 1'b1);                drain();
    issue(3'd7, 32'd5, 32'd0, 5'd11, 1'b1);                drain();
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1); drain();
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1); drain();

    // Random operations with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        default: ;
      endcase
      issue(rop, ra, rb, 5'($urandom_range(0, 31)), 1'b1);
      drain();
    end
    rand_ready = 1'b0;
    OUT_READY  = 1'b1;

    // Consumer stall: result held stable for 10 cycles
    OUT_READY = 1'b0;
    model(3'd5, 32'd1000, 32'd7, hr, hdz, hlat);
    issue(3'd5, 32'd1000, 32'd7, 5'd9, 1'b1);
    n = 0;
    while (!OUT_VALID && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("hold_reached_done", OUT_VALID, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("hold_result", RESULT, hr);
      check("hold_tag", TAG_OUT, 9);
      check("hold_in_ready", IN_READY, 0);
    end
    @(posedge CLK);
    #2 OUT_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("release_in_ready", IN_READY, 1);
    check("release_out_valid", OUT_VALID, 0);
    drain();

    // Flush in CALC cycle 10
    valid_seen = 0;
    issue(3'd5, 32'd12345, 32'd17, 5'd14, 1'b0);
    repeat (9) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush_in_ready", IN_READY, 1);
    repeat (40) @(negedge CLK);
    check("flush_no_valid", valid_seen, 0);

    // Flush overrides a simultaneous request
    @(negedge CLK);
    IN_VALID = 1'b1; OP = 3'd0; DATA1 = 32'd2; DATA2 = 32'd2; FLUSH = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0; FLUSH = 1'b0;
    check("flush_drop_in_ready", IN_READY, 1);

    // Reset pulse in CALC cycle 20
    valid_seen = 0;
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 1'b0);
    repeat (19) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("midrst_in_ready", IN_READY, 1);
    check("midrst_out_valid", OUT_VALID, 0);
    check("midrst_tag_out", TAG_OUT, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (40) @(negedge CLK);
    check("midrst_no_valid", valid_seen, 0);
    check("midrst_idle", IN_READY, 1);

    // Request taken on the first rising edge after reset release
    @(negedge CLK);
    RESET_N = 1'b0;
    @(posedge CLK);
    #3 RESET_N = 1'b1;
    issue(3'd0, 32'd3, 32'd4, 5'd16, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
